// File: rtl/fpu_pkg.sv
// Shared FPU definitions used by the integer-to-float convert path.
//   rm_e        rounding-mode encoding (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4)
//   fp_flags_t  exception flag bundle {inexact, overflow}
//   exp_bias    exponent bias for a given exponent width
//   exp_max     all-ones (inf/nan) exponent code for a given exponent width
package fpu_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   typedef struct packed {
      logic inexact;
      logic overflow;
   } fp_flags_t;

   function automatic int exp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int exp_max(input int exp_w);
      return (1 << exp_w) - 1;
   endfunction

endpackage

// File: rtl/lzc.sv
// Parametrised leading-zero counter, purely combinational.
//   data      operand
//   count     number of leading zeros (W when data is all zero)
//   all_zero  data == 0
module lzc #(
   parameter int W = 32
) (
   input  logic [W-1:0]       data,
   output logic [$clog2(W):0] count,
   output logic               all_zero
);

   localparam int CW = $clog2(W) + 1;

   // Ascending scan: the highest set bit is the last to write count.
   always_comb begin
      count = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (data[i]) count = CW'(W - 1 - i);
      end
   end

   assign all_zero = ~|data;

endmodule

// File: rtl/itof_pipe.sv
// Pipelined integer-to-float converter with in-block rounding and packing.
// Stages: S1 abs/sign, S2 leading-zero count + normalise, S3 round/pack
// into the output register. One global stall: every stage advances when
// the output register is empty or being consumed.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake
//   in_int, in_unsigned   operand and its signedness
//   in_rm                 rounding mode (used only with ITOF_ROUND_MODES_EN)
//   out_valid/out_ready   result handshake
//   out_result            {sign, exponent, fraction}
//   out_inexact           rounding discarded nonzero bits (or overflow)
//   out_overflow          rounded exponent reached the inf code
// Build option: ITOF_ROUND_MODES_EN enables in_rm; without it every
// conversion rounds to nearest-even and overflow always saturates to inf.
module itof_pipe
   import fpu_pkg::*;
#(
   parameter int INT_W = 32,
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INT_W-1:0]       in_int,
   input  logic                   in_unsigned,
   input  logic [2:0]             in_rm,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic                   out_inexact,
   output logic                   out_overflow
);

   localparam int BIAS  = exp_bias(EXP_W);
   localparam int EMAX  = exp_max(EXP_W);
   localparam int LZ_W  = $clog2(INT_W) + 1;
   localparam int EXT_W = INT_W + MAN_W + 1;

   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // S1: sign and magnitude
   logic             in_sign;
   logic             s1_valid, s1_sign;
   logic [INT_W-1:0] s1_mag;

   assign in_sign = in_int[INT_W-1] & ~in_unsigned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_sign  <= in_sign;
         s1_mag   <= in_sign ? (~in_int + INT_W'(1)) : in_int;
      end
   end

   // S2: normalise so the leading one sits at the MSB
   logic [LZ_W-1:0]  lz;
   logic             mag_zero;
   logic             s2_valid, s2_sign, s2_zero;
   logic [LZ_W-1:0]  s2_lz;
   logic [INT_W-1:0] s2_norm;

   lzc #(.W(INT_W)) u_lzc (
      .data     (s1_mag),
      .count    (lz),
      .all_zero (mag_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_zero  <= 1'b0;
         s2_lz    <= '0;
         s2_norm  <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_zero  <= mag_zero;
         s2_lz    <= lz;
         s2_norm  <= s1_mag << lz;
      end
   end

   // Rounding mode travels with its operand
   rm_e rm_eff;
`ifdef ITOF_ROUND_MODES_EN
   logic [2:0] s1_rm, s2_rm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_rm <= '0;
         s2_rm <= '0;
      end else if (advance) begin
         s1_rm <= in_rm;
         s2_rm <= s1_rm;
      end
   end

   // Reserved encodings 5..7 fall back to nearest-even.
   assign rm_eff = (s2_rm > 3'd4) ? RM_RNE : rm_e'(s2_rm);
`else
   logic unused_rm;
   assign unused_rm = ^in_rm;
   assign rm_eff    = RM_RNE;
`endif

   // S3: round and pack
   // The normalised MSB is the hidden bit and never stored.
   logic                 unused_hidden;
   logic [EXT_W-1:0]     ext;
   logic [MAN_W-1:0]     frac, frac_rnd;
   logic                 guard, sticky, rnd_inc, carry, ovf, max_fin;
   int                   exp_rnd;
   logic [EXP_W+MAN_W:0] res_nxt;
   fp_flags_t            flags_nxt;

   assign unused_hidden = s2_norm[INT_W-1];

   always_comb begin
      // Zero padding below the fraction makes guard/sticky vanish when the
      // integer already fits in the fraction.
      ext     = {s2_norm[INT_W-2:0], {(MAN_W + 2){1'b0}}};
      frac    = ext[EXT_W-1 -: MAN_W];
      guard   = ext[INT_W];
      sticky  = |ext[INT_W-1:0];
      case (rm_eff)
         RM_RTZ:  rnd_inc = 1'b0;
         RM_RDN:  rnd_inc = s2_sign & (guard | sticky);
         RM_RUP:  rnd_inc = ~s2_sign & (guard | sticky);
         RM_RMM:  rnd_inc = guard;
         default: rnd_inc = guard & (sticky | frac[0]);
      endcase
      {carry, frac_rnd} = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_inc};
      exp_rnd = BIAS + INT_W - 1 - int'(s2_lz) + int'(carry);
      ovf     = (exp_rnd >= EMAX);
      max_fin = (rm_eff == RM_RTZ) | ((rm_eff == RM_RDN) & ~s2_sign)
              | ((rm_eff == RM_RUP) & s2_sign);
      flags_nxt.inexact  = guard | sticky | ovf;
      flags_nxt.overflow = ovf;
      if (s2_zero) begin
         res_nxt   = '0;
         flags_nxt = '0;
      end else if (ovf) begin
         res_nxt = max_fin ? {s2_sign, EXP_W'(EMAX - 1), {MAN_W{1'b1}}}
                           : {s2_sign, EXP_W'(EMAX), {MAN_W{1'b0}}};
      end else begin
         res_nxt = {s2_sign, EXP_W'(exp_rnd), frac_rnd};
      end
   end

   fp_flags_t out_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (advance) begin
         out_valid  <= s2_valid;
         out_result <= res_nxt;
         out_flags  <= flags_nxt;
      end
   end

   assign out_inexact  = out_flags.inexact;
   assign out_overflow = out_flags.overflow;

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: a single-precision instance checked cycle by cycle
// against an arithmetic reference model, plus a half-width-exponent
// instance for the overflow paths.
module tb_itof_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid = 1'b0, in_unsigned = 1'b0, out_ready = 1'b1;
   logic [31:0] in_int = '0;
   logic [2:0]  in_rm = '0;
   logic        in_ready, out_valid, out_inexact, out_overflow;
   logic [31:0] out_result;

   logic        h_in_valid = 1'b0, h_in_unsigned = 1'b0, h_out_ready = 1'b1;
   logic [31:0] h_in_int = '0;
   logic [2:0]  h_in_rm = '0;
   logic        h_in_ready, h_out_valid, h_out_inexact, h_out_overflow;
   logic [15:0] h_out_result;

   always #5 clk = ~clk;

   itof_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_int(in_int), .in_unsigned(in_unsigned), .in_rm(in_rm),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_inexact(out_inexact), .out_overflow(out_overflow));

   itof_pipe #(.INT_W(32), .EXP_W(5), .MAN_W(10)) u_dut_h (
      .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .in_int(h_in_int), .in_unsigned(h_in_unsigned), .in_rm(h_in_rm),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .out_result(h_out_result),
      .out_inexact(h_out_inexact), .out_overflow(h_out_overflow));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] res;
      logic        inx;
      logic        ovf;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference: locate the leading one, split value into kept bits and a
   // remainder, and round by comparing the remainder with half an ulp.
   function automatic void model(input logic [31:0] v, input logic u, input logic [2:0] rm_in,
                                 input int ew, input int mw,
                                 output logic [63:0] res, output logic inx, output logic ovf);
      logic               sgn, up;
      logic [2:0]         rm;
      longint unsigned    mag, m, rem, half;
      int                 p, sh, e, bias, emax;
`ifdef ITOF_ROUND_MODES_EN
      rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
`else
      rm = (rm_in == 3'd7) ? 3'd0 : 3'd0;
`endif
      sgn = v[31] & ~u;
      mag = sgn ? (64'h1_0000_0000 - {32'b0, v}) : {32'b0, v};
      res = '0; inx = 1'b0; ovf = 1'b0;
      if (mag == 0) return;
      p = 63;
      while (p > 0 && !mag[p]) p--;
      bias = (1 << (ew - 1)) - 1;
      emax = (1 << ew) - 1;
      if (p <= mw) begin
         m = mag << (mw - p);
         up = 1'b0;
      end else begin
         sh   = p - mw;
         m    = mag >> sh;
         rem  = mag - (m << sh);
         half = 64'd1 << (sh - 1);
         inx  = (rem != 0);
         case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = sgn && rem != 0;
            3'd3:    up = !sgn && rem != 0;
            3'd4:    up = rem >= half;
            default: up = rem > half || (rem == half && m[0]);
         endcase
      end
      m = m + longint'(up);
      if (m == (64'd2 << mw)) begin
         m = m >> 1;
         p++;
      end
      e = bias + p;
      if (e >= emax) begin
         ovf = 1'b1;
         inx = 1'b1;
         if (rm == 3'd1 || (rm == 3'd2 && !sgn) || (rm == 3'd3 && sgn))
            res = (64'(sgn) << (ew + mw)) | (64'(emax - 1) << mw) | ((64'd1 << mw) - 1);
         else
            res = (64'(sgn) << (ew + mw)) | (64'(emax) << mw);
      end else begin
         res = (64'(sgn) << (ew + mw)) | (64'(e) << mw) | (m & ((64'd1 << mw) - 1));
      end
   endfunction

   // Compare process: captures accepted operands into the scoreboard and
   // checks every consumed result, the stall rule and output stability.
   initial begin
      exp_t        e;
      logic [63:0] r;
      logic        ix, ov;
      logic        held = 1'b0;
      logic [31:0] held_res = '0;
      logic        held_inx = 1'b0, held_ovf = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            held = 1'b0;
            check("reset_out_valid", 64'(out_valid), 64'd0);
         end else begin
            if (held) begin
               check("hold_result", 64'(out_result), 64'(held_res));
               check("hold_flags", 64'({out_inexact, out_overflow}), 64'({held_inx, held_ovf}));
            end
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 64'(out_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("result", 64'(out_result), 64'(e.res));
                  check("inexact", 64'(out_inexact), 64'(e.inx));
                  check("overflow", 64'(out_overflow), 64'(e.ovf));
               end
            end
            if (in_valid && in_ready) begin
               model(in_int, in_unsigned, in_rm, 8, 23, r, ix, ov);
               e.res = r[31:0];
               e.inx = ix;
               e.ovf = ov;
               exp_q.push_back(e);
            end
            held     = out_valid && !out_ready;
            held_res = out_result;
            held_inx = out_inexact;
            held_ovf = out_overflow;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] v, input logic u, input logic [2:0] rm);
      int n;
      in_valid = 1'b1; in_int = v; in_unsigned = u; in_rm = rm;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   task automatic latency(input string name, input logic [31:0] v);
      int n;
      out_ready = 1'b1;
      send(v, 1'b0, 3'd0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      check(name, 64'(n), 64'd3);
      tick();
   endtask

   // Model pinned by hand-derived literals; the operand is also sent to the DUT.
   task automatic pin(input string name, input logic [31:0] v, input logic u, input logic [2:0] rm,
                      input logic [31:0] req, input logic req_inx);
      logic [63:0] r;
      logic        ix, ov;
      model(v, u, rm, 8, 23, r, ix, ov);
      check(name, r, 64'(req));
      check({name, "_inx"}, 64'(ix), 64'(req_inx));
      send(v, u, rm);
   endtask

   task automatic run_h(input string name, input logic [31:0] v, input logic u, input logic [2:0] rm,
                        input logic [15:0] req, input logic req_ovf);
      logic [63:0] r;
      logic        ix, ov;
      int          n;
      model(v, u, rm, 5, 10, r, ix, ov);
      check({name, "_model"}, r, 64'(req));
      check({name, "_model_ovf"}, 64'(ov), 64'(req_ovf));
      h_in_valid = 1'b1; h_in_int = v; h_in_unsigned = u; h_in_rm = rm;
      tick();
      h_in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!h_out_valid && n < 10);
      check({name, "_res"}, 64'(h_out_result), 64'(r[15:0]));
      check({name, "_ovf"}, 64'(h_out_overflow), 64'(ov));
      check({name, "_inx"}, 64'(h_out_inexact), 64'(ix));
      tick();
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return $urandom >> $urandom_range(0, 31);
         2:       return 32'hFFFF_FFFF - ($urandom >> $urandom_range(4, 31));
         default: return (32'd1 << $urandom_range(0, 31)) | 32'($urandom_range(0, 3));
      endcase
   endfunction

   logic done;

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_result", 64'(out_result), 64'd0);
      check("reset_flags", 64'({out_inexact, out_overflow}), 64'd0);
      check("reset_h_valid", 64'(h_out_valid), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", 64'(in_ready), 64'd1);
      tick();

      pin("one",        32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0);
      pin("minus_one",  32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0);
      pin("zero",       32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0);
      pin("min_signed", 32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0);
      pin("min_uns",    32'h8000_0000, 1'b1, 3'd0, 32'h4F00_0000, 1'b0);
      pin("tie_even",   32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1);
      pin("tie_odd",    32'h0100_0003, 1'b0, 3'd0, 32'h4B80_0002, 1'b1);
      pin("carry_exp",  32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1);
      pin("rtz",        32'h0100_0001, 1'b0, 3'd1, 32'h4B80_0000, 1'b1);
      pin("rm7_as_rne", 32'h0100_0003, 1'b0, 3'd7, 32'h4B80_0002, 1'b1);
`ifdef ITOF_ROUND_MODES_EN
      pin("rup",        32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1);
      pin("rdn_neg",    32'hFEFF_FFFF, 1'b0, 3'd2, 32'hCB80_0001, 1'b1);
`else
      pin("rup",        32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0000, 1'b1);
      pin("rdn_neg",    32'hFEFF_FFFF, 1'b0, 3'd2, 32'hCB80_0000, 1'b1);
`endif
      drain();

      run_h("h_1000",    32'd1000,      1'b1, 3'd0, 16'h63D0, 1'b0);
      run_h("h_ovf_rne", 32'h0001_0000, 1'b0, 3'd0, 16'h7C00, 1'b1);
      run_h("h_rnd_ovf", 32'h0000_FFFF, 1'b1, 3'd0, 16'h7C00, 1'b1);
`ifdef ITOF_ROUND_MODES_EN
      run_h("h_ovf_rtz", 32'h0001_0000, 1'b0, 3'd1, 16'h7BFF, 1'b1);
      run_h("h_neg_rup", 32'hFFFF_0000, 1'b0, 3'd3, 16'hFBFF, 1'b1);
`else
      run_h("h_ovf_rtz", 32'h0001_0000, 1'b0, 3'd1, 16'h7C00, 1'b1);
      run_h("h_neg_rup", 32'hFFFF_0000, 1'b0, 3'd3, 16'hFC00, 1'b1);
`endif

      latency("latency", 32'd12345);
      drain();

      // Back-pressure mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) send(rand_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         end
         begin
            repeat (3) tick();
            out_ready = 1'b0;
            repeat (2) tick();
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            repeat (3) tick();
            out_ready = 1'b1;
         end
      join
      drain();

      // Long random run with random gaps and random back-pressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(rand_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
               if ($urandom_range(0, 3) == 0) tick();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               tick();
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three operands in flight
      out_ready = 1'b0;
      send(32'd111, 1'b0, 3'd0);
      send(32'd222, 1'b0, 3'd0);
      send(32'd333, 1'b0, 3'd0);
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      tick();
      rst_n = 1'b0;
      #1 check("reset_async_out_valid", 64'(out_valid), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_ghost_output", 64'(out_valid), 64'd0);
      end
      tick();
      latency("latency_after_reset", 32'hFFFF_FF00);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
